// File: rtl/instr_fetch_pkg.sv
// Shared constants, fetch-entry payload and buffer state encoding for the fetch stage.
package instr_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ROM_COL_MAX = 64;
    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR  = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEF_IMEM_BYTES = XLEN'(4 * ROM_COL_MAX);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            oob;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fetch_buf.sv
// Two-entry valid/ready FIFO holding fetched {pc, instr, oob} entries; head drives the outputs.
module fetch_buf
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  fetch_entry_t in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output fetch_entry_t out_data
);

    buf_state_t   state;
    buf_state_t   state_next;
    fetch_entry_t tail;
    logic         pop_c;
    logic         push_c;

    assign pop_c      = out_valid & out_ready;
    assign in_ready_c = (state != FULL) | pop_c;
    assign push_c     = in_valid & in_ready_c & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != EMPTY);
        end
    end

    // Occupancy follows count' = count + push - pop; flush empties from any state.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push_c) state_next = ONE;
            ONE: begin
                if (push_c && !pop_c)      state_next = FULL;
                else if (!push_c && pop_c) state_next = EMPTY;
            end
            FULL:    if (pop_c && !push_c) state_next = ONE;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    // Head takes new data when it would otherwise be empty, else advances from tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            tail     <= '0;
        end else begin
            if (push_c && (state == EMPTY || (state == ONE && pop_c))) begin
                out_data <= in_data;
            end else if (pop_c && state == FULL) begin
                out_data <= tail;
            end
            if (push_c && ((state == ONE && !pop_c) || state == FULL)) begin
                tail <= in_data;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// PC register and fetch stage in front of a combinational instruction ROM, with redirect/flush.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] IMEM_BYTES = DEF_IMEM_BYTES,
    parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_oob
);

    logic [31:0]  pc;
    logic         inr_c;
    logic         buf_ready_c;
    logic         push_c;
    fetch_entry_t entry_c;
    fetch_entry_t head;

    assign imem_addr = pc;
    assign inr_c     = (pc < IMEM_BYTES);
    assign push_c    = ~redirect_valid & buf_ready_c;

    // Out-of-range fetches are replaced by a NOP and flagged.
    always_comb begin
        entry_c       = '0;
        entry_c.pc    = pc;
        entry_c.instr = inr_c ? imem_data : NOP_INSTR;
        entry_c.oob   = ~inr_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (push_c) begin
            pc <= pc + 32'd4;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .in_valid   (~redirect_valid),
        .in_ready_c (buf_ready_c),
        .in_data    (entry_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (head)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_oob   = head.oob;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: queue-based stream model checked every cycle plus literal spot checks.
module tb_instr_fetch;

    localparam logic [31:0] IMEM_BYTES = 32'd256;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_oob;

    int vectors = 0;
    int miscompares = 0;

    // Expected stream: PCs waiting in the buffer, plus the next PC to fetch.
    logic [31:0] mq[$];
    logic [31:0] mpc = 32'h0;

    always #5 clk = ~clk;

    // ROM: word k holds the value k.
    assign imem_data = imem_addr >> 2;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_oob        (out_oob)
    );

    function automatic logic [31:0] exp_instr(input logic [31:0] p);
        return (p >= IMEM_BYTES) ? NOP : (p >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Stream model: decode takes the head when ready; a free slot takes the next PC; redirect restarts.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mpc = 32'h0;
            end else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (redirect_valid) begin
                    mq.delete();
                    mpc = redirect_pc & 32'hFFFF_FFFC;
                end else if (mq.size() < 2) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_pc", out_pc, 32'd0);
                chk("rst_instr", out_instr, 32'd0);
                chk("rst_oob", 32'(out_oob), 32'd0);
                chk("rst_addr", imem_addr, 32'd0);
            end else begin
                chk("m_addr", imem_addr, mpc);
                chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
                if (mq.size() > 0) begin
                    chk("m_pc", out_pc, mq[0]);
                    chk("m_instr", out_instr, exp_instr(mq[0]));
                    chk("m_oob", 32'(out_oob), 32'(mq[0] >= IMEM_BYTES));
                end
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_addr", imem_addr, 32'h0);

        // Streaming with decode always ready.
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); chk("s0_valid", 32'(out_valid), 32'd1); chk("s0_pc", out_pc, 32'h0); chk("s0_instr", out_instr, 32'd0);
        tick(); chk("s1_pc", out_pc, 32'h4); chk("s1_instr", out_instr, 32'd1);
        tick(); chk("s2_pc", out_pc, 32'h8); chk("s2_instr", out_instr, 32'd2);

        // Restart with decode stalled: buffer fills, PC holds.
        rst_n = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); chk("st_first_pc", out_pc, 32'h0); chk("st_first_addr", imem_addr, 32'h4);
        repeat (4) tick();
        chk("st_hold_pc", out_pc, 32'h0);
        chk("st_hold_instr", out_instr, 32'd0);
        chk("st_hold_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        tick(); chk("st_rel1", out_pc, 32'h4);
        tick(); chk("st_rel2", out_pc, 32'h8);
        tick(); chk("st_rel3", out_pc, 32'hC);

        // Redirect while full.
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rf_full_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        tick(); chk("rf_bubble", 32'(out_valid), 32'd0); chk("rf_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tick(); chk("rf_pc", out_pc, 32'h40); chk("rf_instr", out_instr, 32'h10);
        tick(); chk("rf_pc2", out_pc, 32'h44);

        // Redirect coinciding with a pop.
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick(); chk("rp_bubble", 32'(out_valid), 32'd0); chk("rp_addr", imem_addr, 32'h80);
        redirect_valid = 1'b0;
        tick(); chk("rp_pc", out_pc, 32'h80);

        // Back-to-back redirects, last one lands just below the ROM end.
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick(); chk("bb_v1", 32'(out_valid), 32'd0);
        redirect_pc = 32'hF8;
        tick(); chk("bb_v2", 32'(out_valid), 32'd0); chk("bb_addr", imem_addr, 32'hF8);
        redirect_valid = 1'b0;
        tick(); chk("end_pc0", out_pc, 32'hF8); chk("end_oob0", 32'(out_oob), 32'd0); chk("end_instr0", out_instr, 32'd62);
        tick(); chk("end_pc1", out_pc, 32'hFC); chk("end_oob1", 32'(out_oob), 32'd0); chk("end_instr1", out_instr, 32'd63);
        tick(); chk("oob_pc", out_pc, 32'h100); chk("oob_flag", 32'(out_oob), 32'd1); chk("oob_instr", out_instr, NOP);
        tick(); chk("oob_pc2", out_pc, 32'h104); chk("oob_flag2", 32'(out_oob), 32'd1);

        // 32-bit PC wrap with an unaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick(); chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick(); chk("wrap_pc", out_pc, 32'hFFFF_FFFC); chk("wrap_oob", 32'(out_oob), 32'd1); chk("wrap_next", imem_addr, 32'h0);
        tick(); chk("wrap_pc0", out_pc, 32'h0); chk("wrap_instr0", out_instr, 32'd0); chk("wrap_oob0", 32'(out_oob), 32'd0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        repeat (2) tick();
        chk("ar_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_pc", out_pc, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); chk("ar_re_pc0", out_pc, 32'h0); chk("ar_re_valid", 32'(out_valid), 32'd1);
        tick(); chk("ar_re_pc1", out_pc, 32'h4);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
